mux4_feeder: RTL

Upstream stage of the 4-input 6-bit selector. It turns a 6-bit command/data byte stream into four held 6-bit operands (`op0`..`op3`) and a 2-bit select. The select is either held at a fixed value or auto-scanned at a programmable rate. Its outputs connect one-to-one to the selector's four data inputs and select input.

---
 rtl/mux4_feeder_pkg.sv | 17 +
 rtl/mux4_feeder_if.sv | 11 +
 rtl/mux4_feeder_sel_scanner.sv | 41 ++++
 rtl/mux4_feeder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mux4_feeder_pkg.sv
// Shared definitions for the mux4_feeder command front end: opcodes,
// FSM state type and operand width.
package mux4_feeder_pkg;

  localparam int W = 6;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_MODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_DATA
  } state_t;

endpackage

// File: rtl/mux4_feeder_if.sv
// Command/data word stream into mux4_feeder. No backpressure: every word
// presented with din_valid high is consumed on that edge.
interface mux4_feeder_if;
  import mux4_feeder_pkg::*;

  logic [W-1:0] din;
  logic         din_valid;

  modport master (output din, output din_valid);
  modport slave  (input  din, input  din_valid);
endinterface

// File: rtl/mux4_feeder_sel_scanner.sv
// Select generator: holds sel/scan_en, reloaded by a MODE strobe, and
// steps sel modulo 4 every SCAN_DIV cycles while scanning.
module sel_scanner #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] load_sel,
  input  logic       load_scan,
  output logic [1:0] sel,
  output logic       scan_en
);

  localparam logic [5:0] DIV_LAST = 6'(SCAN_DIV - 1);

  logic [5:0] div;

  // Reload has priority over a coincident step; divider parks at 0 when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 2'd0;
      scan_en <= 1'b0;
      div     <= 6'd0;
    end else if (load) begin
      sel     <= load_sel;
      scan_en <= load_scan;
      div     <= 6'd0;
    end else if (scan_en) begin
      if (div == DIV_LAST) begin
        div <= 6'd0;
        sel <= sel + 2'd1;
      end else begin
        div <= div + 6'd1;
      end
    end else begin
      div <= 6'd0;
    end
  end

endmodule

// File: rtl/mux4_feeder.sv
// Command front end for the 4-input selector: decodes a 6-bit word stream
// into four held operands, a select (fixed or auto-scanned) and status.
module mux4_feeder
  import mux4_feeder_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  mux4_feeder_if.slave  cmd,
  output logic [W-1:0]  op0,
  output logic [W-1:0]  op1,
  output logic [W-1:0]  op2,
  output logic [W-1:0]  op3,
  output logic [1:0]    sel,
  output logic          scan_en,
  output logic          busy,
  output logic          err
);

  // Abort fires on the edge where the idle count would reach TIMEOUT
  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

  state_t       state, state_nxt;
  logic [1:0]   addr;
  logic [5:0]   tcnt;
  logic [W-1:0] op_q [4];

  logic mode_ld, addr_ld, wr_ld, clr, err_set, err_clr, tcnt_clr, tcnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Command decode and next state; data in WAIT_DATA beats the timeout
  always_comb begin
    state_nxt = state;
    mode_ld   = 1'b0;
    addr_ld   = 1'b0;
    wr_ld     = 1'b0;
    clr       = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd.din_valid) begin
          err_clr = 1'b1;
          case (cmd.din[5:4])
            OP_MODE:  mode_ld = 1'b1;
            OP_WRITE: begin
              addr_ld   = 1'b1;
              tcnt_clr  = 1'b1;
              state_nxt = ST_WAIT_DATA;
            end
            OP_CLEAR: clr = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_WAIT_DATA: begin
        if (cmd.din_valid) begin
          wr_ld     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tcnt == TO_LAST) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tcnt_inc  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers: CLEAR zeroes all, a data word lands at the latched addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) op_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) op_q[i] <= '0;
    end else if (wr_ld) begin
      op_q[addr] <= cmd.din;
    end
  end

  // Write address latched with the WRITE command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       addr <= 2'd0;
    else if (addr_ld) addr <= cmd.din[1:0];
  end

  // Idle-cycle counter for the data-word timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tcnt <= 6'd0;
    else if (tcnt_clr) tcnt <= 6'd0;
    else if (tcnt_inc) tcnt <= tcnt + 6'd1;
  end

  // Sticky timeout flag, cleared by any accepted command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  sel_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mode_ld),
    .load_sel  (cmd.din[1:0]),
    .load_scan (cmd.din[2]),
    .sel       (sel),
    .scan_en   (scan_en)
  );

  assign busy = (state == ST_WAIT_DATA);
  assign op0  = op_q[0];
  assign op1  = op_q[1];
  assign op2  = op_q[2];
  assign op3  = op_q[3];

endmodule
